// File: rtl/alu74181_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
// Function-select codes assume active-high data on the slice.
package alu74181_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_SUB    = 4'b0110;
  localparam logic [3:0] S_XOR    = 4'b0110;
  localparam logic [3:0] S_AND    = 4'b1011;
  localparam logic [3:0] S_OR     = 4'b1110;
  localparam logic [3:0] S_PASS_A = 4'b1111;

  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/alu74181_nibble_seq.sv
// Drives one 74181 slice nibble-serially to build a WIDTH-bit result.
// Define ALU_SEQ_ZERO_FLAG_EN to add the res_zero output.
module alu74181_nibble_seq
  import alu74181_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_cn,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout,
  input  logic             alu_p,
  input  logic             alu_g,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic             res_zero
`endif
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int KW  = idx_w(NIB);
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [KW-1:0]    k_q, k_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic             alu_cn_q, alu_cn_d;
  logic [WIDTH-1:0] res_f_q, res_f_d;
  logic             res_cout_q, res_cout_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  // P/G are unused: carry is rippled, never looked ahead.
  logic unused_pg;
  assign unused_pg = &{1'b0, alu_p, alu_g};

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    s_d        = s_q;
    m_d        = m_q;
    k_d        = k_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cn_d   = alu_cn_q;
    res_f_d    = res_f_q;
    res_cout_d = res_cout_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d     = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = RUN;
          alu_a_d    = req_a[3:0];
          alu_b_d    = req_b[3:0];
          a_sh_d     = req_a >> NIBBLE_W;
          b_sh_d     = req_b >> NIBBLE_W;
          alu_cn_d   = req_cn;
          s_d        = req_s;
          m_d        = req_m;
          k_d        = '0;
          res_f_d    = '0;
          res_cout_d = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero_d     = 1'b1;
`endif
        end
      end
      RUN: begin
        res_f_d[{k_q, 2'b00} +: NIBBLE_W] = alu_f;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_d   = zero_q & (alu_f == 4'd0);
`endif
        alu_a_d  = a_sh_q[3:0];
        alu_b_d  = b_sh_q[3:0];
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        alu_cn_d = alu_cout;
        if (k_q == K_LAST) begin
          res_cout_d = alu_cout;
          state_d    = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      k_q        <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cn_q   <= 1'b0;
      res_f_q    <= '0;
      res_cout_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      s_q        <= s_d;
      m_q        <= m_d;
      k_q        <= k_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cn_q   <= alu_cn_d;
      res_f_q    <= res_f_d;
      res_cout_q <= res_cout_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q     <= zero_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = s_q;
  assign alu_m     = m_q;
  assign alu_cn    = alu_cn_q;
  assign res_f     = res_f_q;
  assign res_cout  = res_cout_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign res_zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu74181_nibble_seq.sv
// Directed bench: sequencer plus a behavioural stub slice (XOR or add).
// Define ALU_SEQ_ZERO_FLAG_EN to also check res_zero.
module tb_alu74181_nibble_seq;
  import alu74181_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_s;
  logic        req_m, req_cn;
  logic [3:0]  alu_a, alu_b, alu_s;
  logic        alu_m, alu_cn;
  logic [3:0]  alu_f;
  logic        alu_cout;
  logic        res_valid, res_ready;
  logic [15:0] res_f;
  logic        res_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        res_zero;
`endif

  logic        stub_add;
  logic [4:0]  sum5;
  logic [3:0]  seq_a [4];
  logic [3:0]  seq_b [4];
  logic        seq_cn [4];
  logic [15:0] hold_f;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu74181_nibble_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s),
    .req_m(req_m), .req_cn(req_cn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cout(alu_cout),
    .alu_p(1'b0), .alu_g(1'b0),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_f(res_f), .res_cout(res_cout)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .res_zero(res_zero)
`endif
  );

  always_comb begin
    sum5 = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cn};
    if (stub_add) begin
      alu_f    = sum5[3:0];
      alu_cout = sum5[4];
    end else begin
      alu_f    = alu_a ^ alu_b;
      alu_cout = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_f"}, 32'(res_f), 32'd0);
    chk({tag, "_res_cout"}, 32'(res_cout), 32'd0);
    chk({tag, "_alu_ab"}, {24'd0, alu_a, alu_b}, 32'd0);
    chk({tag, "_alu_smcn"}, {26'd0, alu_s, alu_m, alu_cn}, 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_res_zero"}, 32'(res_zero), 32'd0);
`endif
  endtask

  // Called at a negedge with the sequencer idle; returns at cycle t+5.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m,
                        input logic cn);
    chk("pre_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a = a; req_b = b; req_s = s; req_m = m; req_cn = cn;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 16'hDEAD; req_b = 16'hBEEF; req_s = 4'h0;
    req_m = ~m; req_cn = ~cn;
    for (int k = 0; k < 4; k++) begin
      seq_a[k]  = alu_a;
      seq_b[k]  = alu_b;
      seq_cn[k] = alu_cn;
      if (k == 0) begin
        chk("run_ready", 32'(req_ready), 32'd0);
        chk("run_s", 32'(alu_s), 32'(s));
        chk("run_m", 32'(alu_m), 32'(m));
      end
      if (k == 3) chk("early_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    chk("res_valid", 32'(res_valid), 32'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_valid", 32'(res_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_cn = 1'b0;
    stub_add = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("in_rst");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    run_op(16'h1234, 16'h00FF, S_XOR, 1'b1, 1'b0);
    chk("xor_alu_a", {16'd0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]},
        32'h4321);
    chk("xor_alu_b", {16'd0, seq_b[0], seq_b[1], seq_b[2], seq_b[3]},
        32'hFF00);
    chk("xor_res", 32'(res_f), 32'h12CB);
    consume();

    stub_add = 1'b1;
    run_op(16'h0FFF, 16'h0001, S_ADD, 1'b0, 1'b0);
    chk("add_cn", {28'd0, seq_cn[0], seq_cn[1], seq_cn[2], seq_cn[3]},
        32'b0111);
    chk("add_res", 32'(res_f), 32'h1000);
    chk("add_cout", 32'(res_cout), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("add_zero", 32'(res_zero), 32'd0);
`endif
    consume();

    run_op(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b0);
    chk("wrap_res", 32'(res_f), 32'h0000);
    chk("wrap_cout", 32'(res_cout), 32'd1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("wrap_zero", 32'(res_zero), 32'd1);
`endif

    hold_f = 16'h0000;
    req_valid = 1'b1;
    req_a = 16'h0001; req_b = 16'h0002; req_s = S_ADD;
    req_m = 1'b0; req_cn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_f", 32'(res_f), 32'(hold_f));
      chk("hold_cout", 32'(res_cout), 32'd1);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    consume();
    req_valid = 1'b0;
    run_op(16'h0001, 16'h0002, S_ADD, 1'b0, 1'b0);
    chk("b2b_res", 32'(res_f), 32'h0003);
    chk("b2b_cout", 32'(res_cout), 32'd0);
    consume();

    req_valid = 1'b1;
    req_a = 16'h5555; req_b = 16'h1111; req_s = S_ADD;
    req_m = 1'b0; req_cn = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("abort");
    @(negedge clk);
    chk("abort_no_valid", 32'(res_valid), 32'd0);

    run_op(16'h1234, 16'h4321, S_ADD, 1'b0, 1'b1);
    chk("after_abort_res", 32'(res_f), 32'h5556);
    chk("after_abort_cout", 32'(res_cout), 32'd0);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
